// File: rtl/pattern_source_32bit.sv
// pattern_source_32bit: registered counter/walking-one/LFSR/fixed/alternating word source driving a FIFO write port
module pattern_source_32bit #(
  parameter logic [31:0] LFSR_SEED  = 32'h0000_0001,
  parameter logic [31:0] FIXED_WORD = 32'hDEAD_BEEF,
  parameter logic [31:0] CNT_START  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic [31:0] pattern,
  input  logic        enable_gener,
  output logic [31:0] dataout,
  output logic        dataout_available,
  output logic [31:0] words_generated,
  output logic        done
);
  localparam logic [31:0] SEED = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state, state_nx;
  logic [2:0]  mode, cur_mode;
  logic [15:0] remain;
  logic        lim_on, fire, last, alt;
  logic [31:0] cnt, walk, lfsr, gen;
  always_comb begin
    cur_mode = state == IDLE ? pattern[2:0] : mode;
    gen      = cur_mode == 3'd1 ? walk :
               cur_mode == 3'd2 ? lfsr :
               cur_mode == 3'd3 ? FIXED_WORD :
               cur_mode == 3'd4 ? (alt ? 32'h5555_5555 : 32'hAAAA_AAAA) : cnt;
    fire     = enable_gener && state != DONE;
    last     = state == IDLE ? pattern[31:16] == 16'd1 : lim_on && remain == 16'd1;
    state_nx = fire ? (last ? DONE : RUN) : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= restart ? IDLE : state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dataout           <= '0;
      dataout_available <= 1'b0;
      words_generated   <= '0;
      mode              <= '0;
      remain            <= '0;
      lim_on            <= 1'b0;
      cnt               <= CNT_START;
      walk              <= 32'h1;
      lfsr              <= SEED;
      alt               <= 1'b0;
    end else if (restart) begin
      dataout           <= '0;
      dataout_available <= 1'b0;
      words_generated   <= '0;
      mode              <= '0;
      remain            <= '0;
      lim_on            <= 1'b0;
      cnt               <= CNT_START;
      walk              <= 32'h1;
      lfsr              <= SEED;
      alt               <= 1'b0;
    end else begin
      dataout_available <= fire;
      if (fire) begin
        dataout         <= gen;
        words_generated <= words_generated + 32'(words_generated != '1);
        cnt             <= cnt + 32'd1;
        walk            <= {walk[30:0], walk[31]};
        lfsr            <= (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
        alt             <= !alt;
        remain          <= (state == IDLE ? pattern[31:16] : remain) - 16'd1;
        if (state == IDLE) begin
          mode   <= pattern[2:0];
          lim_on <= pattern[31:16] != 16'd0;
        end
      end
    end
  assign done = state == DONE;
endmodule

// File: tb/tb_pattern_source_32bit.sv
// tb_pattern_source_32bit: randomized self-checking bench against a word-index reference model
module tb_pattern_source_32bit;
  logic        clk, reset, restart, enable_gener;
  logic [31:0] pattern;
  logic [31:0] dataout, words_generated, dataout2, words2;
  logic        dataout_available, done, av2, done2;
  int vectors = 0, miscompares = 0;
  int m_state, n, m_lim;
  logic [2:0]  m_mode;
  logic [31:0] m_words, exp_do, exp_do2;
  logic        exp_av;
  pattern_source_32bit dut (
    .clk(clk), .reset(reset), .restart(restart), .pattern(pattern),
    .enable_gener(enable_gener), .dataout(dataout), .dataout_available(dataout_available),
    .words_generated(words_generated), .done(done)
  );
  pattern_source_32bit #(.LFSR_SEED(32'h0), .CNT_START(32'hFFFF_FFFE)) dut2 (
    .clk(clk), .reset(reset), .restart(restart), .pattern(pattern),
    .enable_gener(enable_gener), .dataout(dataout2), .dataout_available(av2),
    .words_generated(words2), .done(done2)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] word(input logic [2:0] m, input int k, input logic [31:0] cs);
    logic [31:0] s;
    s = 32'h1;
    case (m)
      3'd1: return 32'h1 << (k % 32);
      3'd2: begin
        for (int i = 0; i < k; i++) s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
        return s;
      end
      3'd3: return 32'hDEAD_BEEF;
      3'd4: return k[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
      default: return cs + 32'(k);
    endcase
  endfunction
  task automatic model_clear();
    m_state = 0; n = 0; m_words = 0; exp_do = 0; exp_do2 = 0; exp_av = 0; m_mode = 0; m_lim = 0;
  endtask
  task automatic check_all();
    chk("dataout", dataout, exp_do);
    chk("avail", 32'(dataout_available), 32'(exp_av));
    chk("done", 32'(done), 32'(m_state == 2));
    chk("words", words_generated, m_words);
    chk("dataout_p", dataout2, exp_do2);
    chk("avail_p", 32'(av2), 32'(exp_av));
  endtask
  task automatic cycle(input logic en, input logic rs, input logic [31:0] pat);
    enable_gener = en; restart = rs; pattern = pat;
    @(posedge clk);
    exp_av = 1'b0;
    if (rs) model_clear();
    else if (en && m_state != 2) begin
      if (m_state == 0) begin m_mode = pat[2:0]; m_lim = int'(pat[31:16]); end
      exp_do  = word(m_mode, n, 32'h0);
      exp_do2 = word(m_mode, n, 32'hFFFF_FFFE);
      exp_av  = 1'b1;
      n++;
      if (m_words != '1) m_words++;
      m_state = (m_lim != 0 && n == m_lim) ? 2 : 1;
    end
    @(negedge clk);
    check_all();
  endtask
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    model_clear();
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    logic [31:0] pat;
    int len;
    reset = 1'b0; restart = 1'b0; enable_gener = 1'b0; pattern = '0;
    model_clear();
    #3 check_all();
    @(negedge clk);
    reset = 1'b1;
    pat = {16'd4, 13'd0, 3'd0};
    repeat (6) cycle(1'b1, 1'b0, pat);
    cycle(1'b0, 1'b1, '0);
    pat = {16'd3, 13'd0, 3'd2};
    repeat (5) cycle(1'b1, 1'b0, pat);
    cycle(1'b1, 1'b1, '0);
    pat = {16'd0, 13'd0, 3'd1};
    cycle(1'b1, 1'b0, pat); cycle(1'b0, 1'b0, pat); cycle(1'b0, 1'b0, pat);
    cycle(1'b1, 1'b0, pat); cycle(1'b1, 1'b0, pat); cycle(1'b0, 1'b0, pat);
    cycle(1'b0, 1'b1, '0);
    pat = {16'd0, 13'd0, 3'd4};
    repeat (3) cycle(1'b1, 1'b0, pat);
    cycle(1'b1, 1'b1, pat);
    repeat (2) cycle(1'b1, 1'b0, pat);
    cycle(1'b0, 1'b1, '0);
    pat = {16'd1, 13'd0, 3'd3};
    repeat (3) cycle(1'b1, 1'b0, pat);
    cycle(1'b0, 1'b1, '0);
    pat = {16'd0, 13'd0, 3'd3};
    repeat (3) cycle(1'b1, 1'b0, pat);
    async_reset();
    cycle(1'b1, 1'b0, pat);
    for (int b = 0; b < 80; b++) begin
      pat = {16'($urandom_range(0, 12)), 13'($urandom), 3'($urandom)};
      len = $urandom_range(3, 30);
      for (int c = 0; c < len; c++)
        cycle(1'($urandom % 4 != 0), 1'b0, m_state == 0 ? pat : $urandom);
      if (b % 9 == 4) async_reset();
      else cycle(1'($urandom), 1'b1, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
